// File: rtl/rrc_symbol_scheduler.sv
// Purpose: paces I/Q symbols into the RRC interpolator at one strobe per SPS clocks, zero-filling gaps and draining the filter at frame end.
// Latency: first strobe two cycles after enable && s_valid in IDLE; each accepted symbol appears on f_i/f_q the cycle after its slot decision.
// Backpressure: s_ready is raised only in RUN on slot 0; a missed slot is filled with a zero symbol and flagged as an underrun, never stalled.
module rrc_symbol_scheduler #(
  parameter int SPS        = 4,
  parameter int FLUSH_SYMS = 10,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [15:0]      s_i,
  input  logic signed [15:0]      s_q,
  input  logic                    s_last,
  output logic                    f_valid,
  output logic signed [15:0]      f_i,
  output logic signed [15:0]      f_q,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    underrun,
  output logic [CNT_W-1:0]        underrun_cnt,
  input  logic                    cnt_clr
);

  localparam int SLOT_W = (SPS > 1) ? $clog2(SPS) : 1;
  localparam int FL_W   = (FLUSH_SYMS > 0) ? $clog2(FLUSH_SYMS + 1) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SPS - 1);
  localparam logic [FL_W-1:0]   FLUSH_INIT = FL_W'(FLUSH_SYMS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t            state;
  logic [SLOT_W-1:0] slot_cnt;
  logic [FL_W-1:0]   flush_cnt;

  logic slot0;
  logic slot_wrap;
  logic run_take;
  logic run_miss;
  logic flush_emit;
  logic flush_exit;

  // Slot-decision qualifiers shared by the FSM and the underrun counter.
  always_comb begin
    slot0      = (slot_cnt == '0);
    slot_wrap  = (slot_cnt == SLOT_LAST);
    s_ready    = (state == RUN) && slot0;
    run_take   = s_ready && s_valid;
    run_miss   = s_ready && !s_valid;
    flush_emit = (state == FLUSH) && slot0 && (flush_cnt != '0);
    flush_exit = (state == FLUSH) && (flush_cnt == '0) && slot_wrap;
  end

  // Frame FSM: slot pacing, strobe generation and all registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      slot_cnt   <= '0;
      flush_cnt  <= '0;
      f_valid    <= 1'b0;
      f_i        <= '0;
      f_q        <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      f_valid    <= 1'b0;
      underrun   <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          slot_cnt <= '0;
          if (enable && s_valid) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          slot_cnt <= slot_wrap ? '0 : slot_cnt + 1'b1;
          if (run_take) begin
            f_valid <= 1'b1;
            f_i     <= s_i;
            f_q     <= s_q;
            if (s_last) begin
              state     <= FLUSH;
              flush_cnt <= FLUSH_INIT;
            end
          end else if (run_miss) begin
            // Keep the filter fed at symbol rate even when the source is late.
            f_valid  <= 1'b1;
            f_i      <= '0;
            f_q      <= '0;
            underrun <= 1'b1;
          end
        end
        FLUSH: begin
          slot_cnt <= slot_wrap ? '0 : slot_cnt + 1'b1;
          if (flush_emit) begin
            f_valid   <= 1'b1;
            f_i       <= '0;
            f_q       <= '0;
            flush_cnt <= flush_cnt - 1'b1;
          end
          // Leaving on the last slot of an empty period keeps at least SPS+1
          // cycles between the final drain strobe and the next frame.
          if (flush_exit) begin
            state      <= IDLE;
            slot_cnt   <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          slot_cnt <= '0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  // Saturating underrun counter; a clear beats a coincident increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_cnt <= '0;
    end else if (cnt_clr) begin
      underrun_cnt <= '0;
    end else if (run_miss && !(&underrun_cnt)) begin
      underrun_cnt <= underrun_cnt + 1'b1;
    end
  end

endmodule
